// File: rtl/and_serial_reducer.sv
// and_serial_reducer
// Bit-serial AND reduction of a LENGTH-bit word received over a valid/ready
// stream. Also reports the index of the first zero bit. The result is held
// on a valid/ready output port until the consumer takes it.
module and_serial_reducer #(
    parameter  int LENGTH = 8,
    localparam int CW     = $clog2(LENGTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_bit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out,
    output logic [CW-1:0] first_zero
);

    localparam logic [CW-1:0] LEN_CW  = CW'(LENGTH);
    localparam logic [CW-1:0] LAST_CW = CW'(LENGTH - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   fz_q, fz_d;
    logic            out_q, out_d;
    logic [CW-1:0]   first_zero_q, first_zero_d;

    logic            accept;
    logic            handshake;
    logic            acc_next;
    logic [CW-1:0]   fz_next;

    // Handshake strobes come only from registered state, so the ready/valid
    // outputs never combinationally depend on the partner's signals.
    assign in_ready   = (state_q == COLLECT);
    assign out_valid  = (state_q == HOLD);
    assign out        = out_q;
    assign first_zero = first_zero_q;

    // Next-state logic: fold accepted bits into the running AND, remember the
    // first zero, and publish the result when the last bit of a word lands.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        fz_d         = fz_q;
        out_d        = out_q;
        first_zero_d = first_zero_q;

        accept    = in_valid && (state_q == COLLECT);
        handshake = out_ready && (state_q == HOLD);

        acc_next = acc_q & in_bit;
        fz_next  = (!in_bit && (fz_q == LEN_CW)) ? cnt_q : fz_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    acc_d = acc_next;
                    fz_d  = fz_next;
                    if (cnt_q == LAST_CW) begin
                        state_d      = HOLD;
                        cnt_d        = '0;
                        out_d        = acc_next;
                        first_zero_d = fz_next;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (handshake) begin
                    state_d = COLLECT;
                    acc_d   = 1'b1;
                    fz_d    = LEN_CW;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            acc_q        <= 1'b1;
            cnt_q        <= '0;
            fz_q         <= LEN_CW;
            out_q        <= 1'b1;
            first_zero_q <= LEN_CW;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            fz_q         <= fz_d;
            out_q        <= out_d;
            first_zero_q <= first_zero_d;
        end
    end

endmodule

// File: tb/tb_and_serial_reducer.sv
// Testbench for and_serial_reducer: directed and random streams for the
// LENGTH=8 build, plus a short directed sequence on a LENGTH=1 build.
module tb_and_serial_reducer;

    localparam int L  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_bit, out_ready;
    logic          in_ready, out_valid, out;
    logic [CW-1:0] first_zero;

    logic          in_valid1, in_bit1, out_ready1;
    logic          in_ready1, out_valid1, out1;
    logic          first_zero1;

    int checks = 0;
    int errors = 0;

    // Scoreboard of {out, first_zero} results for the LENGTH=8 build
    logic [4:0] expQ[$];
    logic       modelHold;
    int         modelCnt;
    logic [7:0] modelWord;
    int         pushed;
    int         popped;

    always #5 clk = ~clk;

    and_serial_reducer #(.LENGTH(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .first_zero (first_zero)
    );

    and_serial_reducer #(.LENGTH(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .in_bit     (in_bit1),
        .out_valid  (out_valid1),
        .out_ready  (out_ready1),
        .out        (out1),
        .first_zero (first_zero1)
    );

    // Reference result: AND of the word and lowest zero index (or L)
    function automatic logic [4:0] refResult(input logic [7:0] w);
        logic [3:0] fz;
        fz = 4'(L);
        for (int i = L - 1; i >= 0; i--) begin
            if (!w[i]) fz = 4'(i);
        end
        return {&w, fz};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the LENGTH=8 build, called at a falling edge
    task automatic applyStimulus(input logic v, input logic b, input logic r);
        in_valid  = v;
        in_bit    = b;
        out_ready = r;
        checkOutput("in_ready", 32'(in_ready), 32'(!modelHold));
        checkOutput("out_valid", 32'(out_valid), 32'(modelHold));
        if (modelHold) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            end else begin
                checkOutput("out", 32'(out), 32'(expQ[0][4]));
                checkOutput("first_zero", 32'(first_zero), 32'(expQ[0][3:0]));
                if (r) begin
                    void'(expQ.pop_front());
                    popped++;
                    modelHold = 1'b0;
                end
            end
        end else if (v) begin
            modelWord[modelCnt] = b;
            modelCnt++;
            if (modelCnt == L) begin
                expQ.push_back(refResult(modelWord));
                pushed++;
                modelHold = 1'b1;
                modelCnt  = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse reset for one cycle and discard any model state
    task automatic resetDut();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_bit     = 1'b0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_bit1    = 1'b0;
        out_ready1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        modelHold = 1'b0;
        modelCnt  = 0;
        modelWord = '0;
        expQ.delete();
    endtask

    initial begin
        logic [7:0] pat;
        int cyc;
        pushed = 0;
        popped = 0;
        @(negedge clk);
        resetDut();

        // Reset values on both builds
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out", 32'(out), 32'd1);
        checkOutput("rst_first_zero", 32'(first_zero), 32'd8);
        checkOutput("rst1_first_zero", 32'(first_zero1), 32'd1);
        checkOutput("rst1_out_valid", 32'(out_valid1), 32'd0);

        // Test 1: all ones at full rate
        for (int i = 0; i < L; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t1_out", 32'(out), 32'd1);
        checkOutput("t1_first_zero", 32'(first_zero), 32'd8);
        applyStimulus(1'b1, 1'b0, 1'b1);

        // Test 2: zeros at index 3 and 5, then an all-ones word
        pat = 8'b1101_0111;
        for (int i = 0; i < L; i++) applyStimulus(1'b1, pat[i], 1'b1);
        checkOutput("t2_out", 32'(out), 32'd0);
        checkOutput("t2_first_zero", 32'(first_zero), 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < L; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t2b_out", 32'(out), 32'd1);
        checkOutput("t2b_first_zero", 32'(first_zero), 32'd8);
        applyStimulus(1'b0, 1'b0, 1'b1);

        // Test 3: back-pressure with zero bits offered during HOLD
        pat = 8'b1011_1111;
        for (int i = 0; i < L; i++) applyStimulus(1'b1, pat[i], 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t3_out", 32'(out), 32'd0);
        checkOutput("t3_first_zero", 32'(first_zero), 32'd6);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < L; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t3b_first_zero", 32'(first_zero), 32'd8);
        applyStimulus(1'b0, 1'b0, 1'b1);

        // Test 4: reset in the middle of a word discards it
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        resetDut();
        for (int i = 0; i < L; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t4_out", 32'(out), 32'd1);
        checkOutput("t4_first_zero", 32'(first_zero), 32'd8);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);

        // Test 5: random traffic over 200 words
        pushed = 0;
        popped = 0;
        cyc    = 0;
        while (popped < 200 && cyc < 20000) begin
            applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            cyc++;
        end
        checkOutput("t5_results", 32'(popped), 32'd200);
        checkOutput("t5_queue_left", 32'(expQ.size()), 32'(pushed - popped));

        // Test 6: LENGTH=1 build, bits 0 then 1
        in_valid1  = 1'b1;
        in_bit1    = 1'b0;
        out_ready1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t6a_out_valid", 32'(out_valid1), 32'd1);
        checkOutput("t6a_out", 32'(out1), 32'd0);
        checkOutput("t6a_first_zero", 32'(first_zero1), 32'd0);
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t6_in_ready", 32'(in_ready1), 32'd1);
        in_valid1  = 1'b1;
        in_bit1    = 1'b1;
        out_ready1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t6b_out_valid", 32'(out_valid1), 32'd1);
        checkOutput("t6b_out", 32'(out1), 32'd1);
        checkOutput("t6b_first_zero", 32'(first_zero1), 32'd1);
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
